// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types and opcode constants for the multicycle RV32I control unit.
package multicycle_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R,
    S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_AUIPC, S_LUI, S_ERROR
  } ctrl_state_t;

  typedef enum logic {ADR_PC, ADR_RESULT} AdrSrc_t;
  typedef enum logic [1:0] {ALU_PC, ALU_OLD_PC, ALU_RD1} ALUSrcA_t;
  typedef enum logic [1:0] {ALU_RD2, ALU_EXTEND, ALU_PLUS_4} ALUsource_t;
  typedef enum logic [1:0] {RESULT_FROM_ALU, RESULT_FROM_MEM, RESULT_FROM_PC4} ResultSource_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } ALUop_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} IMM_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Immediate format the extender must produce while decoding this opcode.
  function automatic IMM_t imm_for_opcode(input logic [6:0] opcode);
    case (opcode)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_JAL:           return IMM_J;
      OP_AUIPC, OP_LUI: return IMM_U;
      default:          return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_alu_decoder.sv
// Maps R/I-type funct3/funct7 to the ALU operation.
module alu_decoder
  import multicycle_ctrl_fsm_pkg::*;
(
  input  logic       is_r,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output ALUop_t     alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      3'b000:  alu_op = (is_r && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = funct7_b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences the shared-ALU
// datapath one state per clock and counts retired instructions.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter ctrl_state_t RESET_STATE = S_FETCH,
  parameter int          INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 zero,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output AdrSrc_t              AdrSrc,
  output ALUSrcA_t             ALUSrcA,
  output ALUsource_t           ALUSrc,
  output ResultSource_t        ResultSrc,
  output ALUop_t               ALUControl,
  output IMM_t                 ImmSrc,
  output logic                 illegal_instr,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

  ctrl_state_t state, next_state;
  logic        pc_write_c, ir_write_c, reg_write_c, mem_write_c, retire;
  ALUop_t      rtype_op;
  logic        unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  alu_decoder u_alu_decoder (
    .is_r      (opcode == OP_R),
    .funct3    (funct3),
    .funct7_b5 (funct7[5]),
    .alu_op    (rtype_op)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RESET_STATE;
      instret       <= '0;
      illegal_instr <= 1'b0;
    end else begin
      state <= next_state;
      if (retire) instret <= instret + INSTRET_ONE;
      if (state == S_ERROR) illegal_instr <= 1'b1;
    end
  end

  always_comb begin
    next_state  = state;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    mem_write_c = 1'b0;
    retire      = 1'b0;
    AdrSrc      = ADR_PC;
    ALUSrcA     = ALU_RD1;
    ALUSrc      = ALU_RD2;
    ResultSrc   = RESULT_FROM_ALU;
    ALUControl  = ALU_ADD;
    ImmSrc      = IMM_I;
    case (state)
      S_FETCH: begin
        ir_write_c = 1'b1;
        pc_write_c = 1'b1;
        ALUSrcA    = ALU_PC;
        ALUSrc     = ALU_PLUS_4;
        ResultSrc  = RESULT_FROM_PC4;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        // Precompute OldPC + imm so branch/jump targets sit in ALUOut.
        ALUSrcA = ALU_OLD_PC;
        ALUSrc  = ALU_EXTEND;
        ImmSrc  = imm_for_opcode(opcode);
        case (opcode)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXEC_R;
          OP_I:              next_state = S_EXEC_I;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          OP_AUIPC:          next_state = S_AUIPC;
          OP_LUI:            next_state = S_LUI;
          default:           next_state = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        ALUSrc     = ALU_EXTEND;
        ImmSrc     = (opcode == OP_STORE) ? IMM_S : IMM_I;
        next_state = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc     = ADR_RESULT;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc   = RESULT_FROM_MEM;
        reg_write_c = 1'b1;
        retire      = 1'b1;
        next_state  = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc      = ADR_RESULT;
        mem_write_c = 1'b1;
        retire      = 1'b1;
        next_state  = S_FETCH;
      end
      S_EXEC_R: begin
        ALUControl = rtype_op;
        next_state = S_ALUWB;
      end
      S_EXEC_I: begin
        ALUSrc     = ALU_EXTEND;
        ALUControl = rtype_op;
        next_state = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA    = ALU_OLD_PC;
        ALUSrc     = ALU_EXTEND;
        ImmSrc     = IMM_U;
        next_state = S_ALUWB;
      end
      S_LUI: begin
        ALUSrc     = ALU_EXTEND;
        ImmSrc     = IMM_U;
        ALUControl = ALU_PASS_B;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        retire      = 1'b1;
        next_state  = S_FETCH;
      end
      S_BRANCH: begin
        ALUControl = ALU_SUB;
        pc_write_c = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_JAL: begin
        // Link value OldPC+4 lands in ALUOut while the target in ALUOut loads the PC.
        ALUSrcA    = ALU_OLD_PC;
        ALUSrc     = ALU_PLUS_4;
        pc_write_c = 1'b1;
        next_state = S_ALUWB;
      end
      S_JALR: begin
        ALUSrc     = ALU_EXTEND;
        next_state = S_JAL;
      end
      S_ERROR: next_state = S_ERROR;
      default: next_state = S_ERROR;
    endcase
  end

  assign PCWrite  = pc_write_c  & ~rst;
  assign IRWrite  = ir_write_c  & ~rst;
  assign RegWrite = reg_write_c & ~rst;
  assign MemWrite = mem_write_c & ~rst;

endmodule
